// File: rtl/ffapuf_eval_ctrl.sv
// Evaluation sequencer for the flip-flop arbiter PUF: arms, races and samples the PUF
// NEVAL times per challenge, then returns a majority-voted response and an unstable-bit mask.
module ffapuf_eval_ctrl #(
    parameter int CW      = 32,
    parameter int RW      = 32,
    parameter int NEVAL   = 5,
    parameter int CLR_CYC = 2,
    parameter int SETTLE  = 8
) (
    input  logic          clk,
    input  logic          clear,
    input  logic          chal_valid,
    output logic          chal_ready,
    input  logic [CW-1:0] chal_data,
    output logic          puf_clear,
    output logic          puf_clr,
    output logic [CW-1:0] puf_c,
    input  logic [RW-1:0] puf_o,
    output logic          resp_valid,
    input  logic          resp_ready,
    output logic [RW-1:0] resp_data,
    output logic [RW-1:0] resp_unstable,
    output logic          busy,
    output logic [2:0]    state_dbg
);

    localparam int VW   = $clog2(NEVAL + 1);
    localparam int PMAX = (CLR_CYC > SETTLE) ? CLR_CYC : SETTLE;
    localparam int PW   = $clog2(PMAX + 1);

    localparam logic [VW-1:0] NEVAL_V   = VW'(NEVAL);
    localparam logic [VW-1:0] LAST_EVAL = VW'(NEVAL - 1);
    localparam logic [VW-1:0] HALF      = VW'(NEVAL / 2);
    localparam logic [PW-1:0] ARM_LAST  = PW'(CLR_CYC - 1);
    localparam logic [PW-1:0] RACE_LAST = PW'(SETTLE - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ARM    = 3'd1,
        S_RACE   = 3'd2,
        S_SAMPLE = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t        state, state_n;
    logic [PW-1:0] phase;
    logic [VW-1:0] eval_cnt;
    logic [VW-1:0] vote [RW];
    logic [VW-1:0] vsum [RW];
    logic          ctl;
    logic          accept;
    logic          last_eval;

    // Both channels transfer on a rising edge where valid and ready are high; a producer
    // holds valid and its payload until that edge, and ready never depends on valid.
    assign accept    = (state == S_IDLE) && chal_valid;
    assign last_eval = (eval_cnt == LAST_EVAL);

    always_ff @(posedge clk or posedge clear) begin
        if (clear) state <= S_IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n    = state;
        chal_ready = 1'b0;
        busy       = 1'b1;
        case (state)
            S_IDLE: begin
                chal_ready = 1'b1;
                busy       = 1'b0;
                if (accept) state_n = S_ARM;
            end
            S_ARM:    if (phase == ARM_LAST)  state_n = S_RACE;
            S_RACE:   if (phase == RACE_LAST) state_n = S_SAMPLE;
            S_SAMPLE: state_n = last_eval ? S_DONE : S_ARM;
            S_DONE:   if (resp_ready) state_n = S_IDLE;
            default:  state_n = S_IDLE;
        endcase
    end

    // Running vote including the bit being sampled this cycle.
    always_comb begin
        for (int i = 0; i < RW; i++) vsum[i] = vote[i] + VW'(puf_o[i]);
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            phase         <= '0;
            eval_cnt      <= '0;
            puf_c         <= '0;
            ctl           <= 1'b1;
            resp_valid    <= 1'b0;
            resp_data     <= '0;
            resp_unstable <= '0;
            for (int i = 0; i < RW; i++) vote[i] <= '0;
        end else begin
            // PUF controls are registered from the next state so they never glitch.
            ctl <= (state_n == S_IDLE) || (state_n == S_ARM) || (state_n == S_DONE);

            if ((state == S_ARM || state == S_RACE) && state_n == state) phase <= phase + PW'(1);
            else                                                         phase <= '0;

            if (accept) begin
                puf_c    <= chal_data;
                eval_cnt <= '0;
                for (int i = 0; i < RW; i++) vote[i] <= '0;
            end

            if (state == S_SAMPLE) begin
                eval_cnt <= eval_cnt + VW'(1);
                for (int i = 0; i < RW; i++) vote[i] <= vsum[i];
                if (last_eval) begin
                    resp_valid <= 1'b1;
                    for (int i = 0; i < RW; i++) begin
                        resp_data[i]     <= (vsum[i] > HALF);
                        resp_unstable[i] <= (vsum[i] != '0) && (vsum[i] != NEVAL_V);
                    end
                end
            end

            if (state == S_DONE && resp_ready) resp_valid <= 1'b0;
        end
    end

    assign puf_clear = ctl;
    assign puf_clr   = ctl;
    assign state_dbg = state;

endmodule

// File: tb/tb_ffapuf_eval_ctrl.sv
// Bench for ffapuf_eval_ctrl: a timing-driven PUF model feeds responses only in the
// sampling cycle and noise elsewhere; results are compared with a vote-counting model.
module tb_ffapuf_eval_ctrl;

    localparam int CW       = 32;
    localparam int RW       = 32;
    localparam int NEVAL    = 5;
    localparam int CLR_CYC  = 2;
    localparam int SETTLE   = 8;
    localparam int EVAL_CYC = CLR_CYC + SETTLE + 1;
    localparam int LAT      = NEVAL * EVAL_CYC;

    logic          clk;
    logic          clear;
    logic          chal_valid;
    logic          chal_ready;
    logic [CW-1:0] chal_data;
    logic          puf_clear;
    logic          puf_clr;
    logic [CW-1:0] puf_c;
    logic [RW-1:0] puf_o;
    logic          resp_valid;
    logic          resp_ready;
    logic [RW-1:0] resp_data;
    logic [RW-1:0] resp_unstable;
    logic          busy;
    logic [2:0]    state_dbg;

    int vectors;
    int miscompares;

    logic [RW-1:0] pat [NEVAL];
    logic          clr_tr  [256];
    logic          clr2_tr [256];
    int            puf_c_bad;

    ffapuf_eval_ctrl #(
        .CW(CW), .RW(RW), .NEVAL(NEVAL), .CLR_CYC(CLR_CYC), .SETTLE(SETTLE)
    ) dut (
        .clk(clk), .clear(clear),
        .chal_valid(chal_valid), .chal_ready(chal_ready), .chal_data(chal_data),
        .puf_clear(puf_clear), .puf_clr(puf_clr), .puf_c(puf_c), .puf_o(puf_o),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .resp_unstable(resp_unstable),
        .busy(busy), .state_dbg(state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    task automatic model_resp(output logic [RW-1:0] d, output logic [RW-1:0] u);
        for (int b = 0; b < RW; b++) begin
            int cnt;
            cnt = 0;
            for (int e = 0; e < NEVAL; e++) cnt += int'(pat[e][b]);
            d[b] = (2 * cnt > NEVAL);
            u[b] = (cnt != 0) && (cnt != NEVAL);
        end
    endtask

    task automatic fill_pat_random();
        for (int e = 0; e < NEVAL; e++) pat[e] = $urandom;
    endtask

    task automatic fill_pat_const(input logic [RW-1:0] v);
        for (int e = 0; e < NEVAL; e++) pat[e] = v;
    endtask

    // ---------------- driver tasks ----------------
    // Presents one challenge, then plays the PUF: the pattern for evaluation e is driven
    // only in the cycle after SETTLE low cycles (the sampling cycle), noise otherwise.
    task automatic send_challenge(input logic [CW-1:0] c, input int abort_at,
                                  output int latency, output bit timed_out);
        int k;
        int low;
        int ev;
        timed_out = 1'b0;
        k = 0;
        while (chal_ready !== 1'b1 && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        if (chal_ready !== 1'b1) begin
            timed_out = 1'b1;
            latency   = -1;
            return;
        end
        chal_valid = 1'b1;
        chal_data  = c;
        @(posedge clk); #1;
        chal_valid = 1'b0;
        chal_data  = $urandom;
        k = 0;
        low = 0;
        ev = 0;
        puf_c_bad = 0;
        while (1) begin
            clr_tr[k]  = puf_clear;
            clr2_tr[k] = puf_clr;
            if (puf_c !== c) puf_c_bad++;
            if (k == abort_at) begin
                clear = 1'b1;
                #1;
                break;
            end
            if (resp_valid === 1'b1) break;
            if (k >= 200) begin
                timed_out = 1'b1;
                break;
            end
            low = (puf_clear === 1'b0) ? low + 1 : 0;
            if (low == SETTLE + 1) begin
                puf_o = pat[ev % NEVAL];
                ev++;
            end else begin
                puf_o = $urandom;
            end
            @(posedge clk); #1;
            k++;
        end
        latency = k;
    endtask

    task automatic take_resp(input int delay);
        repeat (delay) begin
            @(posedge clk); #1;
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        clear = 1'b1;
        chal_valid = 1'b0;
        chal_data = '0;
        resp_ready = 1'b0;
        puf_o = '0;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if ({chal_ready, busy, puf_clear, puf_clr, resp_valid} !== 5'b10110) begin
            $display("FAIL reset_ctrl: got %b expected 10110", {chal_ready, busy, puf_clear, puf_clr, resp_valid});
            miscompares++;
        end
        vectors++;
        if ({puf_c, resp_data, resp_unstable} !== '0) begin
            $display("FAIL reset_data: got puf_c=%h data=%h unst=%h expected all 0", puf_c, resp_data, resp_unstable);
            miscompares++;
        end
        clear = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        vectors++;
        if ({chal_ready, busy, puf_clear, puf_clr, resp_valid} !== 5'b10110) begin
            $display("FAIL idle_ctrl: got %b expected 10110", {chal_ready, busy, puf_clear, puf_clr, resp_valid});
            miscompares++;
        end
    endtask

    task automatic test_constant();
        int lat;
        bit tmo;
        logic [RW-1:0] ed, eu;
        fill_pat_const(32'hA5A5_5A5A);
        send_challenge(32'h1234_5678, -1, lat, tmo);
        vectors++;
        if (tmo || lat != LAT) begin
            $display("FAIL const_latency: got %0d (timeout=%0d) expected %0d", lat, tmo, LAT);
            miscompares++;
        end
        vectors++;
        if (puf_c !== 32'h1234_5678 || puf_c_bad != 0) begin
            $display("FAIL const_puf_c: got %h (%0d unstable cycles) expected 12345678", puf_c, puf_c_bad);
            miscompares++;
        end
        model_resp(ed, eu);
        vectors++;
        if (resp_data !== 32'hA5A5_5A5A || resp_data !== ed) begin
            $display("FAIL const_data: got %h expected a5a55a5a", resp_data);
            miscompares++;
        end
        vectors++;
        if (resp_unstable !== '0 || eu !== '0) begin
            $display("FAIL const_unstable: got %h expected 0", resp_unstable);
            miscompares++;
        end
        take_resp(0);
        vectors++;
        if ({chal_ready, busy, resp_valid} !== 3'b100 || resp_data !== 32'hA5A5_5A5A) begin
            $display("FAIL const_handshake: got rdy/busy/vld=%b data=%h expected 100 a5a55a5a",
                     {chal_ready, busy, resp_valid}, resp_data);
            miscompares++;
        end
    endtask

    task automatic test_vote();
        int lat;
        bit tmo;
        pat[0] = 32'h1; pat[1] = 32'h0; pat[2] = 32'h1; pat[3] = 32'h2; pat[4] = 32'h3;
        send_challenge($urandom, -1, lat, tmo);
        vectors++;
        if (tmo || resp_data !== 32'h1) begin
            $display("FAIL vote_data: got %h (timeout=%0d) expected 00000001", resp_data, tmo);
            miscompares++;
        end
        vectors++;
        if (resp_unstable !== 32'h3) begin
            $display("FAIL vote_unstable: got %h expected 00000003", resp_unstable);
            miscompares++;
        end
        take_resp(1);
    endtask

    task automatic test_phase_timing();
        int lat;
        bit tmo;
        logic exp_c;
        fill_pat_random();
        send_challenge($urandom, -1, lat, tmo);
        vectors++;
        if (tmo || lat != LAT) begin
            $display("FAIL phase_latency: got %0d (timeout=%0d) expected %0d", lat, tmo, LAT);
            miscompares++;
        end else begin
            for (int k = 0; k <= LAT; k++) begin
                exp_c = (k == LAT) ? 1'b1 : ((k % EVAL_CYC) < CLR_CYC);
                vectors++;
                if ({clr_tr[k], clr2_tr[k]} !== {exp_c, exp_c}) begin
                    $display("FAIL phase_ctrl cycle %0d: got clear/clr=%b%b expected %b%b",
                             k, clr_tr[k], clr2_tr[k], exp_c, exp_c);
                    miscompares++;
                end
            end
        end
        take_resp(0);
    endtask

    task automatic test_random();
        int lat;
        bit tmo;
        logic [CW-1:0] c;
        logic [RW-1:0] ed, eu;
        for (int t = 0; t < 8; t++) begin
            fill_pat_random();
            c = $urandom;
            send_challenge(c, -1, lat, tmo);
            model_resp(ed, eu);
            vectors++;
            if (tmo || lat != LAT || puf_c_bad != 0) begin
                $display("FAIL rand_timing t%0d: got lat=%0d timeout=%0d puf_c_bad=%0d expected lat=%0d",
                         t, lat, tmo, puf_c_bad, LAT);
                miscompares++;
            end
            vectors++;
            if (resp_data !== ed || resp_unstable !== eu) begin
                $display("FAIL rand_resp t%0d: got %h/%h expected %h/%h", t, resp_data, resp_unstable, ed, eu);
                miscompares++;
            end
            take_resp($urandom_range(0, 3));
        end
    endtask

    task automatic test_hold();
        int lat;
        bit tmo;
        logic [CW-1:0] c;
        logic [RW-1:0] ed, eu;
        fill_pat_random();
        c = $urandom;
        send_challenge(c, -1, lat, tmo);
        model_resp(ed, eu);
        for (int k = 0; k < 20; k++) begin
            chal_valid = 1'b1;
            chal_data  = $urandom;
            @(posedge clk); #1;
            vectors++;
            if ({resp_valid, chal_ready, busy} !== 3'b101 || resp_data !== ed ||
                resp_unstable !== eu || puf_c !== c) begin
                $display("FAIL hold cycle %0d: got vld/rdy/busy=%b data=%h unst=%h puf_c=%h expected 101 %h %h %h",
                         k, {resp_valid, chal_ready, busy}, resp_data, resp_unstable, puf_c, ed, eu, c);
                miscompares++;
            end
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        chal_valid = 1'b0;
        vectors++;
        if ({resp_valid, chal_ready, busy} !== 3'b010 || puf_c !== c || resp_data !== ed) begin
            $display("FAIL hold_release: got vld/rdy/busy=%b puf_c=%h data=%h expected 010 %h %h",
                     {resp_valid, chal_ready, busy}, puf_c, resp_data, c, ed);
            miscompares++;
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        bit tmo;
        logic [CW-1:0] c;
        logic [RW-1:0] ed, eu;
        for (int t = 0; t < 2; t++) begin
            fill_pat_random();
            c = $urandom;
            send_challenge(c, -1, lat, tmo);
            model_resp(ed, eu);
            vectors++;
            if (tmo || lat != LAT || resp_data !== ed || resp_unstable !== eu) begin
                $display("FAIL b2b t%0d: got lat=%0d data=%h unst=%h expected lat=%0d %h %h",
                         t, lat, resp_data, resp_unstable, LAT, ed, eu);
                miscompares++;
            end
            take_resp(0);
        end
    endtask

    task automatic test_abort();
        int lat;
        bit tmo;
        logic [CW-1:0] c;
        fill_pat_random();
        send_challenge($urandom, 2 * EVAL_CYC + CLR_CYC + 3, lat, tmo);
        vectors++;
        if ({chal_ready, busy, puf_clear, puf_clr, resp_valid} !== 5'b10110) begin
            $display("FAIL abort_ctrl: got %b expected 10110", {chal_ready, busy, puf_clear, puf_clr, resp_valid});
            miscompares++;
        end
        vectors++;
        if ({puf_c, resp_data, resp_unstable} !== '0) begin
            $display("FAIL abort_data: got puf_c=%h data=%h unst=%h expected all 0", puf_c, resp_data, resp_unstable);
            miscompares++;
        end
        repeat (2) @(posedge clk);
        #1;
        clear = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if ({chal_ready, busy, resp_valid} !== 3'b100) begin
            $display("FAIL abort_idle: got %b expected 100", {chal_ready, busy, resp_valid});
            miscompares++;
        end
        fill_pat_const(32'hFFFF_FFFF);
        c = $urandom;
        send_challenge(c, -1, lat, tmo);
        vectors++;
        if (tmo || lat != LAT || resp_data !== 32'hFFFF_FFFF || resp_unstable !== '0) begin
            $display("FAIL abort_next: got lat=%0d data=%h unst=%h expected lat=%0d ffffffff 0",
                     lat, resp_data, resp_unstable, LAT);
            miscompares++;
        end
        take_resp(0);
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_constant();
        test_vote();
        test_phase_timing();
        test_random();
        test_hold();
        test_back_to_back();
        test_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
